// File: rtl/tanh_pipe.sv
// tanh_pipe: streaming piecewise-linear tanh for signed Q(IW).(FW) data.
// Four register stages with a single global stall (valid/ready, full backpressure).
// Optional feature macro: TANH_SIGMOID_EN adds port mode_sig selecting sigmoid(x).
module tanh_pipe #(
    parameter int IW        = 4,
    parameter int FW        = 12,
    parameter int SEG_BITS  = 5,
    parameter int XMAX_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW+FW-1:0] in_x,
`ifdef TANH_SIGMOID_EN
    input  logic             mode_sig,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW+FW-1:0] out_y
);

    localparam int W    = IW + FW;
    localparam int AB   = FW + XMAX_LOG2;       // magnitude bits inside the unsaturated range
    localparam int NSEG = 2 ** SEG_BITS;
    localparam int FB   = AB - SEG_BITS;        // interpolation fraction bits
    localparam int MW   = FW + 1;               // table/magnitude width (mag <= 2^FW)
    localparam int PW   = MW + FB + 1;          // slope*fraction product width

    // Breakpoint value, rounded to nearest, evaluated at elaboration only.
    function automatic int tbl_entry(input int k);
        real xr;
        xr = real'(k) * (2.0 ** real'(XMAX_LOG2 - SEG_BITS));
        return $rtoi($tanh(xr) * (2.0 ** real'(FW)) + 0.5);
    endfunction

    logic [MW-1:0] tbl [NSEG+1];

    for (genvar k = 0; k <= NSEG; k++) begin : g_tbl
        localparam int Entry = tbl_entry(k);
        assign tbl[k] = MW'(Entry);
    end

    logic              adv;
    logic              v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic              s0_neg_q, s0_neg_d, s0_sat_q, s0_sat_d;
    logic [AB-1:0]     s0_a_q, s0_a_d;
    logic              s1_neg_q, s1_neg_d, s1_sat_q, s1_sat_d;
    logic [MW-1:0]     s1_y0_q, s1_y0_d, s1_y1_q, s1_y1_d;
    logic [FB-1:0]     s1_f_q, s1_f_d;
    logic              s2_neg_q, s2_neg_d, s2_sat_q, s2_sat_d;
    logic [MW-1:0]     s2_y0_q, s2_y0_d;
    logic [PW-1:0]     s2_p_q, s2_p_d;
    logic [W-1:0]      out_y_q, out_y_d;
    logic [W-1:0]      x_eff, a_full, ymag, y;
    logic [SEG_BITS-1:0] idx;
    logic [MW-1:0]     mag;
`ifdef TANH_SIGMOID_EN
    logic              m0_q, m0_d, m1_q, m1_d, m2_q, m2_d;
    logic [W:0]        sig_sum;
`endif

    // Whole pipe advances together unless a result is waiting on downstream.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;

    // Next-state datapath for all four stages.
    always_comb begin
        // S0: magnitude, sign and saturation detect
        x_eff = in_x;
`ifdef TANH_SIGMOID_EN
        m0_d = mode_sig;
        m1_d = m0_q;
        m2_d = m1_q;
        if (mode_sig) x_eff = {in_x[W-1], in_x[W-1:1]};
`endif
        a_full   = x_eff[W-1] ? ((~x_eff) + W'(1)) : x_eff;
        v0_d     = in_valid;
        s0_neg_d = x_eff[W-1];
        s0_sat_d = (x_eff == {1'b1, {(W-1){1'b0}}}) || (|a_full[W-1:AB]);
        s0_a_d   = a_full[AB-1:0];

        // S1: breakpoint pair lookup, fraction latched
        idx      = s0_a_q[AB-1 -: SEG_BITS];
        v1_d     = v0_q;
        s1_neg_d = s0_neg_q;
        s1_sat_d = s0_sat_q;
        s1_y0_d  = tbl[{1'b0, idx}];
        s1_y1_d  = tbl[{1'b0, idx} + (SEG_BITS+1)'(1)];
        s1_f_d   = s0_a_q[FB-1:0];

        // S2: slope times fraction plus half-LSB rounding constant
        v2_d     = v1_q;
        s2_neg_d = s1_neg_q;
        s2_sat_d = s1_sat_q;
        s2_y0_d  = s1_y0_q;
        s2_p_d   = PW'(s1_y1_q - s1_y0_q) * PW'(s1_f_q) + (PW'(1) << (FB - 1));

        // S3: finish rounding, saturate, restore sign
        mag = s2_y0_q + MW'(s2_p_q >> FB);
        if (s2_sat_q) mag = tbl[NSEG];
        ymag = W'(mag);
        y    = s2_neg_q ? ((~ymag) + W'(1)) : ymag;
`ifdef TANH_SIGMOID_EN
        sig_sum = (W+1)'(2 ** FW) + {y[W-1], y} + (W+1)'(1);
        if (m2_q) y = sig_sum[W:1];
`endif
        out_valid_d = v2_q;
        out_y_d     = y;
    end

    // Stage registers: cleared on reset, frozen as a block while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; out_valid_q <= 1'b0;
            s0_neg_q <= 1'b0; s0_sat_q <= 1'b0; s0_a_q <= '0;
            s1_neg_q <= 1'b0; s1_sat_q <= 1'b0; s1_y0_q <= '0; s1_y1_q <= '0; s1_f_q <= '0;
            s2_neg_q <= 1'b0; s2_sat_q <= 1'b0; s2_y0_q <= '0; s2_p_q <= '0;
            out_y_q <= '0;
`ifdef TANH_SIGMOID_EN
            m0_q <= 1'b0; m1_q <= 1'b0; m2_q <= 1'b0;
`endif
        end else if (adv) begin
            v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d; out_valid_q <= out_valid_d;
            s0_neg_q <= s0_neg_d; s0_sat_q <= s0_sat_d; s0_a_q <= s0_a_d;
            s1_neg_q <= s1_neg_d; s1_sat_q <= s1_sat_d; s1_y0_q <= s1_y0_d;
            s1_y1_q <= s1_y1_d; s1_f_q <= s1_f_d;
            s2_neg_q <= s2_neg_d; s2_sat_q <= s2_sat_d; s2_y0_q <= s2_y0_d; s2_p_q <= s2_p_d;
            out_y_q <= out_y_d;
`ifdef TANH_SIGMOID_EN
            m0_q <= m0_d; m1_q <= m1_d; m2_q <= m2_d;
`endif
        end
    end

endmodule

// File: tb/tb_tanh_pipe.sv
// Testbench for tanh_pipe (default build): scoreboard of expected results, directed steps.
module tb_tanh_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_x, out_y;

    always #5 clk = ~clk;

    tanh_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    int          checks = 0;
    int          errors = 0;
    int          tbl [33];
    logic [15:0] sb [$];
    bit          accepted;
    bit          use_ovr;
    logic [15:0] ovr;
    logic [15:0] vals [6];
    logic [15:0] held;
    int          n;

    // Reference: odd-symmetric PWL interpolation on a 33-point tanh table, Q4.12.
    function automatic logic [15:0] model(input logic [15:0] x);
        int xi, a, idx, f, mag;
        xi = int'(signed'(x));
        a  = (xi < 0) ? -xi : xi;
        if (a >= 16384) mag = tbl[32];
        else begin
            idx = a / 512;
            f   = a % 512;
            mag = tbl[idx] + ((tbl[idx+1] - tbl[idx]) * f + 256) / 512;
        end
        return (xi < 0) ? 16'(-mag) : 16'(mag);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard push on accept, pop/compare on retire, then step past posedge.
    task automatic tick();
        @(negedge clk);
        accepted = 1'b0;
        if (rst) sb.delete();
        else begin
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                sb.push_back(use_ovr ? ovr : model(in_x));
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL spurious_out: observed out_y 0x%h with empty scoreboard, expected no output", out_y);
                end
                if (sb.size() > 0) check("y", out_y, sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input bit rnd, input bit ov, input logic [15:0] ev);
        in_valid = 1'b1;
        in_x     = x;
        use_ovr  = ov;
        ovr      = ev;
        accepted = 1'b0;
        for (int t = 0; t < 64 && !accepted; t++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        checks++;
        assert (accepted) else begin
            errors++;
            $error("FAIL send_timeout: observed no accept of x=0x%h, expected accept within 64 cycles", x);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        use_ovr   = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sb.size() > 0; t++) tick();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d results outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        for (int k = 0; k <= 32; k++) tbl[k] = $rtoi($tanh(real'(k) / 8.0) * 4096.0 + 0.5);
        vals = '{16'h0800, 16'hF800, 16'h1B33, 16'h2400, 16'hE000, 16'h0C00};
        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1; use_ovr = 1'b0; ovr = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", 16'(out_valid), 16'h0000);
        check("rst_out_y", out_y, 16'h0000);
        check("rst_in_ready", 16'(in_ready), 16'h0001);

        // Latency: accepting edge counts as the first of four edges.
        in_valid = 1'b1; in_x = 16'h0000; use_ovr = 1'b1; ovr = 16'h0000;
        tick();
        in_valid = 1'b0; use_ovr = 1'b0;
        check("lat_accept", 16'(accepted), 16'h0001);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("lat_valid_edge%0d", c + 1), 16'(out_valid), (c == 3) ? 16'h0001 : 16'h0000);
            if (c < 3) tick();
        end
        check("lat_y_zero", out_y, 16'h0000);
        drain();

        // Directed values, back to back at full rate.
        send(16'h1000, 1'b0, 1'b1, 16'h0C2F);
        send(16'hF000, 1'b0, 1'b1, 16'hF3D1);
        send(16'h1B33, 1'b0, 1'b1, 16'h0EF6);
        send(16'h4000, 1'b0, 1'b1, 16'h0FFD);
        send(16'h7FFF, 1'b0, 1'b1, 16'h0FFD);
        send(16'h8000, 1'b0, 1'b1, 16'hF003);
        send(16'hC000, 1'b0, 1'b1, 16'hF003);
        send(16'h3FFF, 1'b0, 1'b0, 16'h0000);
        send(16'hC001, 1'b0, 1'b0, 16'h0000);
        send(16'h0001, 1'b0, 1'b0, 16'h0000);
        send(16'h0200, 1'b0, 1'b0, 16'h0000);
        drain();

        // Backpressure: out_ready low for 10 cycles while 6 samples are offered.
        out_ready = 1'b0;
        n = 0;
        held = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (n < 6);
            in_x     = (n < 6) ? vals[n] : 16'h0000;
            use_ovr  = 1'b0;
            tick();
            if (accepted) n++;
            if (c == 3) held = out_y;
            if (c >= 4) begin
                check($sformatf("stall_valid_c%0d", c), 16'(out_valid), 16'h0001);
                check($sformatf("stall_y_c%0d", c), out_y, held);
            end
        end
        check("stall_accepted", 16'(n), 16'd4);
        check("stall_in_ready", 16'(in_ready), 16'h0000);
        out_ready = 1'b1;
        while (n < 6) begin
            send(vals[n], 1'b0, 1'b0, 16'h0000);
            n++;
        end
        drain();

        // Strided code sweep with random downstream backpressure.
        for (int i = 0; i < 5000; i++) send(16'(i * 13 + 5), 1'b1, 1'b0, 16'h0000);
        drain();

        // Reset mid-stream discards in-flight samples.
        send(16'h0800, 1'b0, 1'b0, 16'h0000);
        send(16'h1000, 1'b0, 1'b0, 16'h0000);
        send(16'hE000, 1'b0, 1'b0, 16'h0000);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("post_rst_valid_c%0d", c), 16'(out_valid), 16'h0000);
            tick();
        end
        send(16'h1000, 1'b0, 1'b1, 16'h0C2F);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
